// File: rtl/i2c_master_sequencer_if.sv
// Request/response and bit-engine handshake between the EEPROM sequencer and its neighbours.
// master = sequencer view, slave = requester / timer / bit-engine view.
interface i2c_master_sequencer_if;
  logic       i_Req;
  logic       i_RW;
  logic [6:0] i_Chip_Addr;
  logic [7:0] i_Reg_Addr;
  logic [7:0] i_Wr_Data;
  logic       i_Timer_Flag;
  logic       i_Ack_n;
  logic [7:0] i_Rx_Byte;
  logic [2:0] o_Current_State;
  logic [7:0] o_Tx_Byte;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Ack_Err;
  logic [7:0] o_Rd_Data;

  modport master (
    input  i_Req, i_RW, i_Chip_Addr, i_Reg_Addr, i_Wr_Data, i_Timer_Flag, i_Ack_n, i_Rx_Byte,
    output o_Current_State, o_Tx_Byte, o_Busy, o_Done, o_Ack_Err, o_Rd_Data
  );
  modport slave (
    output i_Req, i_RW, i_Chip_Addr, i_Reg_Addr, i_Wr_Data, i_Timer_Flag, i_Ack_n, i_Rx_Byte,
    input  o_Current_State, o_Tx_Byte, o_Busy, o_Done, o_Ack_Err, o_Rd_Data
  );
endinterface

// File: rtl/i2c_master_sequencer.sv
// I2C EEPROM transaction sequencer: byte write / random read phases, ACK check,
// chip-address NACK retry with an idle gap, read data return with a done pulse.
module i2c_master_sequencer #(
  parameter int RETRY_MAX = 3,
  parameter int IDLE_GAP  = 15
) (
  input logic                         i_clk10MHz,
  input logic                         i_RST_n,
  i2c_master_sequencer_if.master      bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_CHIP  = 3'd2,
    S_REG   = 3'd3,
    S_DSEND = 3'd4,
    S_DRCV  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  localparam int RW_W = $clog2(RETRY_MAX + 2);
  localparam int GW   = $clog2(IDLE_GAP + 2) + 1;
  localparam logic [RW_W-1:0] L_RMAX     = RW_W'(RETRY_MAX);
  localparam logic [GW-1:0]   L_GAP_LAST = GW'(IDLE_GAP - 1);

  state_t          r_State;
  logic            r_RW;
  logic [6:0]      r_Chip;
  logic [7:0]      r_Reg;
  logic [7:0]      r_Wd;
  logic [7:0]      r_Tx;
  logic            r_Busy;
  logic            r_Done;
  logic            r_Ack_Err;
  logic [7:0]      r_Rd;
  logic [RW_W-1:0] r_Retry;
  logic [GW-1:0]   r_Gap;
  logic            r_Second;
  logic            r_Pend;
  logic            r_Abort;

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_State   <= S_IDLE;
      r_RW      <= 1'b0;
      r_Chip    <= '0;
      r_Reg     <= '0;
      r_Wd      <= '0;
      r_Tx      <= '0;
      r_Busy    <= 1'b0;
      r_Done    <= 1'b0;
      r_Ack_Err <= 1'b0;
      r_Rd      <= '0;
      r_Retry   <= '0;
      r_Gap     <= '0;
      r_Second  <= 1'b0;
      r_Pend    <= 1'b0;
      r_Abort   <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          // Busy while Idle means we are sitting out the gap before a retry Start
          if (!r_Busy) begin
            if (bus.i_Req) begin
              r_RW      <= bus.i_RW;
              r_Chip    <= bus.i_Chip_Addr;
              r_Reg     <= bus.i_Reg_Addr;
              r_Wd      <= bus.i_Wr_Data;
              r_Busy    <= 1'b1;
              r_Ack_Err <= 1'b0;
              r_Retry   <= '0;
              r_Pend    <= 1'b0;
              r_Abort   <= 1'b0;
              r_Second  <= 1'b0;
              r_State   <= S_START;
            end
          end else if (r_Gap == L_GAP_LAST) begin
            r_State <= S_START;
          end else begin
            r_Gap <= r_Gap + 1'b1;
          end
        end
        S_START: if (bus.i_Timer_Flag) begin
          r_Tx    <= {r_Chip, r_Second};
          r_State <= S_CHIP;
        end
        S_CHIP: if (bus.i_Timer_Flag) begin
          if (bus.i_Ack_n) begin
            r_State <= S_STOP;
            if (r_Retry < L_RMAX) r_Pend  <= 1'b1;
            else                  r_Abort <= 1'b1;
          end else if (r_Second) begin
            r_State <= S_DRCV;
          end else begin
            r_Tx    <= r_Reg;
            r_State <= S_REG;
          end
        end
        S_REG: if (bus.i_Timer_Flag) begin
          if (bus.i_Ack_n) begin
            r_Abort <= 1'b1;
            r_State <= S_STOP;
          end else if (r_RW) begin
            r_Second <= 1'b1;
            r_State  <= S_START;
          end else begin
            r_Tx    <= r_Wd;
            r_State <= S_DSEND;
          end
        end
        S_DSEND: if (bus.i_Timer_Flag) begin
          if (bus.i_Ack_n) r_Abort <= 1'b1;
          r_State <= S_STOP;
        end
        S_DRCV: if (bus.i_Timer_Flag) begin
          r_Rd    <= bus.i_Rx_Byte;
          r_State <= S_STOP;
        end
        S_STOP: if (bus.i_Timer_Flag) begin
          r_Second <= 1'b0;
          r_Pend   <= 1'b0;
          if (r_Pend) begin
            r_Retry <= r_Retry + 1'b1;
            r_Gap   <= '0;
            r_State <= (IDLE_GAP == 0) ? S_START : S_IDLE;
          end else begin
            r_Busy    <= 1'b0;
            r_Done    <= 1'b1;
            r_Ack_Err <= r_Abort;
            r_State   <= S_IDLE;
          end
        end
        default: begin
          r_Busy  <= 1'b0;
          r_State <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Current_State = r_State;
  assign bus.o_Tx_Byte       = r_Tx;
  assign bus.o_Busy          = r_Busy;
  assign bus.o_Done          = r_Done;
  assign bus.o_Ack_Err       = r_Ack_Err;
  assign bus.o_Rd_Data       = r_Rd;
endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: a transaction model expands each request into the phase
// list the bus must walk, and a driver plays timer/bit engine while checking every cycle.
module tb_i2c_master_sequencer;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, CHIP = 3'd2, REGA = 3'd3,
                         DSEND = 3'd4, DRCV = 3'd5, STOP = 3'd6;
  localparam int RMAX = 3, GAP = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  i2c_master_sequencer_if bus();
  i2c_master_sequencer #(.RETRY_MAX(RMAX), .IDLE_GAP(GAP)) dut (
    .i_clk10MHz (clk),
    .i_RST_n    (rst_n),
    .bus        (bus.master)
  );

  typedef struct {
    logic [2:0] st;
    logic [7:0] tx;
    bit         chk_tx;
    bit         ack_n;
    bit         gap;
  } ph_t;

  ph_t        q[$];
  bit         exp_err;
  logic [7:0] rd_model;
  bit         exp_rd_upd;
  logic [7:0] exp_rd_new;
  int         total = 0;
  int         bad   = 0;

  function automatic bit chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push(logic [2:0] st, logic [7:0] tx, bit c, bit a, bit g);
    ph_t p;
    p.st = st; p.tx = tx; p.chk_tx = c; p.ack_n = a; p.gap = g;
    q.push_back(p);
  endtask

  // Transaction model: chip_nacks = how many leading chip-address sends get NACKed;
  // other: 1 = NACK the register address, 2 = NACK the data byte (write) or the
  // read-direction chip address once (read).
  task automatic build(bit rw, logic [6:0] ch, logic [7:0] rg, logic [7:0] wd,
                       logic [7:0] rx, int chip_nacks, int other);
    int  tries;
    bit  used2;
    q.delete();
    tries = 0; used2 = 0; exp_err = 0; exp_rd_upd = 0; exp_rd_new = rx;
    while (1) begin
      push(START, 0, 0, 0, 0);
      if (tries < chip_nacks) begin
        push(CHIP, {ch, 1'b0}, 1, 1, 0);
        push(STOP, 0, 0, 0, 0);
        if (tries < RMAX) begin push(IDLE, 0, 0, 0, 1); tries++; continue; end
        exp_err = 1; break;
      end
      push(CHIP, {ch, 1'b0}, 1, 0, 0);
      if (other == 1) begin
        push(REGA, rg, 1, 1, 0); push(STOP, 0, 0, 0, 0); exp_err = 1; break;
      end
      push(REGA, rg, 1, 0, 0);
      if (!rw) begin
        push(DSEND, wd, 1, other == 2, 0); push(STOP, 0, 0, 0, 0);
        exp_err = (other == 2); break;
      end
      push(START, 0, 0, 0, 0);
      if (other == 2 && !used2) begin
        used2 = 1;
        push(CHIP, {ch, 1'b1}, 1, 1, 0);
        push(STOP, 0, 0, 0, 0);
        if (tries < RMAX) begin push(IDLE, 0, 0, 0, 1); tries++; continue; end
        exp_err = 1; break;
      end
      push(CHIP, {ch, 1'b1}, 1, 0, 0);
      push(DRCV, 0, 0, 0, 0);
      push(STOP, 0, 0, 0, 0);
      exp_rd_upd = 1;
      break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd_model = 8'h00;
  endtask

  task automatic run_txn(bit rw, logic [6:0] ch, logic [7:0] rg, logic [7:0] wd,
                         logic [7:0] rx, int chip_nacks, int other, bit spur);
    ph_t p;
    bit  ok;
    int  n;
    build(rw, ch, rg, wd, rx, chip_nacks, other);
    ok = 1;
    @(negedge clk);
    void'(chk("idle_before_req", {bus.o_Current_State, bus.o_Busy}, {IDLE, 1'b0}));
    bus.i_Req = 1'b1; bus.i_RW = rw; bus.i_Chip_Addr = ch;
    bus.i_Reg_Addr = rg; bus.i_Wr_Data = wd;
    @(negedge clk);
    bus.i_Req = 1'b0;
    bus.i_RW = 1'($urandom); bus.i_Chip_Addr = 7'($urandom);
    bus.i_Reg_Addr = 8'($urandom); bus.i_Wr_Data = 8'($urandom);
    foreach (q[i]) begin
      p = q[i];
      if (p.gap) begin
        for (int c = 0; c < GAP && ok; c++) begin
          ok = chk("gap_idle_busy", {bus.o_Current_State, bus.o_Busy, bus.o_Done},
                   {IDLE, 1'b1, 1'b0});
          @(negedge clk);
        end
        if (!ok) break;
        continue;
      end
      ok = chk("phase_state", bus.o_Current_State, p.st);
      if (!ok) break;
      ok = chk("phase_busy_done", {bus.o_Busy, bus.o_Done}, 2'b10);
      if (ok && p.chk_tx) ok = chk("phase_tx", bus.o_Tx_Byte, p.tx);
      if (!ok) break;
      n = $urandom_range(0, 3);
      for (int c = 0; c < n && ok; c++) begin
        if (spur && c == 0) begin
          bus.i_Req = 1'b1; bus.i_RW = 1'($urandom); bus.i_Chip_Addr = 7'($urandom);
        end
        @(negedge clk);
        bus.i_Req = 1'b0;
        ok = chk("phase_hold", bus.o_Current_State, p.st);
      end
      if (!ok) break;
      bus.i_Timer_Flag = 1'b1; bus.i_Ack_n = p.ack_n; bus.i_Rx_Byte = rx;
      @(negedge clk);
      bus.i_Timer_Flag = 1'b0; bus.i_Ack_n = 1'($urandom); bus.i_Rx_Byte = 8'($urandom);
    end
    if (ok) begin
      if (exp_rd_upd) rd_model = exp_rd_new;
      void'(chk("end_state", bus.o_Current_State, IDLE));
      void'(chk("done_pulse", {bus.o_Done, bus.o_Busy}, 2'b10));
      void'(chk("ack_err", bus.o_Ack_Err, exp_err));
      void'(chk("rd_data", bus.o_Rd_Data, rd_model));
      @(negedge clk);
      void'(chk("done_one_cycle", bus.o_Done, 1'b0));
    end else begin
      do_reset();
    end
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.i_Req = 0; bus.i_RW = 0; bus.i_Chip_Addr = 0; bus.i_Reg_Addr = 0;
    bus.i_Wr_Data = 0; bus.i_Timer_Flag = 0; bus.i_Ack_n = 0; bus.i_Rx_Byte = 0;
    rd_model = 8'h00;
    repeat (2) @(negedge clk);
    void'(chk("reset_vals", {bus.o_Current_State, bus.o_Tx_Byte, bus.o_Busy, bus.o_Done,
                             bus.o_Ack_Err, bus.o_Rd_Data}, 30'h0));
    rst_n = 1'b1;
    // Timer flag in Idle must not move the FSM
    @(negedge clk); bus.i_Timer_Flag = 1'b1;
    @(negedge clk); bus.i_Timer_Flag = 1'b0;
    void'(chk("flag_in_idle", {bus.o_Current_State, bus.o_Busy}, {IDLE, 1'b0}));

    // 1: plain write; pin the model's phase list
    build(0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0);
    void'(chk("model_wr_len", q.size(), 5));
    void'(chk("model_wr_tx", {q[1].tx, q[2].tx, q[3].tx}, 24'hA012A5));
    void'(chk("model_wr_st", {q[0].st, q[1].st, q[2].st, q[3].st, q[4].st}, 15'o12346));
    run_txn(0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0, 0);

    // 2: random read with repeated start
    build(1, 7'h50, 8'h34, 8'h00, 8'h5C, 0, 0);
    void'(chk("model_rd_tx", {q[1].tx, q[2].tx, q[4].tx}, 24'hA034A1));
    run_txn(1, 7'h50, 8'h34, 8'h00, 8'h5C, 0, 0, 0);
    void'(chk("rd_literal", bus.o_Rd_Data, 8'h5C));

    // 3: two chip NACKs then success
    build(0, 7'h50, 8'h01, 8'h02, 8'h00, 2, 0);
    cnt = 0; foreach (q[i]) if (q[i].gap) cnt++;
    void'(chk("model_two_gaps", cnt, 2));
    run_txn(0, 7'h50, 8'h01, 8'h02, 8'h00, 2, 0, 0);

    // 4: retries exhausted
    build(1, 7'h50, 8'h01, 8'h02, 8'h77, 4, 0);
    cnt = 0; foreach (q[i]) if (q[i].st == START) cnt++;
    void'(chk("model_four_starts", cnt, 4));
    run_txn(1, 7'h50, 8'h01, 8'h02, 8'h77, 4, 0, 0);
    void'(chk("exhaust_err", bus.o_Ack_Err, 1'b1));

    // 5: register-address NACK, no retry
    run_txn(0, 7'h51, 8'h9, 8'h3C, 8'h00, 0, 1, 0);

    // 6: request while busy, then reset in Data_Send
    run_txn(0, 7'h22, 8'h44, 8'h66, 8'h00, 0, 0, 1);
    @(negedge clk);
    bus.i_Req = 1; bus.i_RW = 0; bus.i_Chip_Addr = 7'h50; bus.i_Reg_Addr = 8'h1; bus.i_Wr_Data = 8'h2;
    @(negedge clk); bus.i_Req = 0;
    for (int c = 0; c < 3; c++) begin
      bus.i_Timer_Flag = 1; bus.i_Ack_n = 0;
      @(negedge clk); bus.i_Timer_Flag = 0;
    end
    void'(chk("reach_dsend", bus.o_Current_State, DSEND));
    rst_n = 1'b0; #1;
    void'(chk("async_reset_vals", {bus.o_Current_State, bus.o_Tx_Byte, bus.o_Busy, bus.o_Done,
                                   bus.o_Ack_Err, bus.o_Rd_Data}, 30'h0));
    rd_model = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bus.o_Done || bus.o_Busy || bus.o_Current_State != IDLE) cnt++; end
    void'(chk("no_done_after_reset", cnt, 0));

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int nk, ot;
      nk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      ot = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              nk, ot, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
